// File: rtl/demux_pkg.sv
// Shared constants, FSM state encoding and helpers for the 1-to-4 demux/deserializer.
// DEMUX_PARITY_EN adds the S_PAR state for a fifth, even-parity bit per frame.
package demux_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    // The low SEL_W bits of each data state are its lane index.
    typedef enum logic [2:0] {
        S_L0 = 3'd0,
        S_L1 = 3'd1,
        S_L2 = 3'd2,
        S_L3 = 3'd3
`ifdef DEMUX_PARITY_EN
        ,
        S_PAR = 3'd4
`endif
    } state_t;

    function automatic logic [SEL_W-1:0] lane_of(input state_t s);
        return s[SEL_W-1:0];
    endfunction

    function automatic logic even_parity(input logic [LANES-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/demux_frame_fsm.sv
// Auto-mode frame collector: state machine plus shadow register, strobing a completed frame.
// Under DEMUX_PARITY_EN a fifth bit carries even parity and bad frames are flagged.
module demux_frame_fsm
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             auto_en,
    input  logic             mode_chg,
    input  logic             sync_clr,
    input  logic             din,
    input  logic             din_valid,
    output logic             frame_done,
    output logic             frame_bad,
    output logic [LANES-1:0] frame_data
);

    state_t           state;
    state_t           base_state;
    state_t           next_state;
    logic [LANES-1:0] shadow;
    logic [LANES-1:0] base_shadow;
    logic [LANES-1:0] next_shadow;

    // A mode change restarts collection on this very cycle, so the incoming bit lands in lane 0.
    always_comb begin
        base_state  = mode_chg ? S_L0 : state;
        base_shadow = mode_chg ? '0 : shadow;
        next_state  = base_state;
        next_shadow = base_shadow;
        frame_done  = 1'b0;
        frame_bad   = 1'b0;
        frame_data  = base_shadow;

        if (!auto_en || sync_clr) begin
            next_state  = S_L0;
            next_shadow = '0;
        end else if (din_valid) begin
            case (base_state)
`ifdef DEMUX_PARITY_EN
                S_PAR: begin
                    if (even_parity(base_shadow) != din) begin
                        frame_bad = 1'b1;
                    end else begin
                        frame_done = 1'b1;
                    end
                    next_state  = S_L0;
                    next_shadow = '0;
                end
`endif
                default: begin
                    next_shadow[lane_of(base_state)] = din;
                    case (base_state)
                        S_L0:    next_state = S_L1;
                        S_L1:    next_state = S_L2;
                        S_L2:    next_state = S_L3;
`ifdef DEMUX_PARITY_EN
                        S_L3:    next_state = S_PAR;
`else
                        S_L3: begin
                            frame_data  = next_shadow;
                            frame_done  = 1'b1;
                            next_state  = S_L0;
                            next_shadow = '0;
                        end
`endif
                        default: next_state = S_L0;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_L0;
            shadow <= '0;
        end else begin
            state  <= next_state;
            shadow <= next_shadow;
        end
    end

endmodule

// File: rtl/demux_1to4_deser.sv
// 1-to-4 demultiplexer with manual (addressed) and auto (deserialize) modes; owns all output registers.
// Build option: DEMUX_PARITY_EN enables 5-bit auto frames with even parity and the parity_err pulse.
module demux_1to4_deser #(
    parameter int unsigned LANES = demux_pkg::LANES,
    parameter int unsigned SEL_W = demux_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             auto_en,
    input  logic             sync_clr,
    output logic [LANES-1:0] data_out,
    output logic [LANES-1:0] lane_upd,
    output logic             frame_valid,
    output logic             parity_err
);

    import demux_pkg::*;

    logic             prev_auto;
    logic             mode_chg;
    logic             frame_done;
    logic             frame_bad;
    logic [LANES-1:0] frame_data;

    assign mode_chg = auto_en ^ prev_auto;

    demux_frame_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .auto_en    (auto_en),
        .mode_chg   (mode_chg),
        .sync_clr   (sync_clr),
        .din        (din),
        .din_valid  (din_valid),
        .frame_done (frame_done),
        .frame_bad  (frame_bad),
        .frame_data (frame_data)
    );

    // frame_done is only ever raised in auto mode, so the two write paths never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= '0;
            lane_upd    <= '0;
            frame_valid <= 1'b0;
            prev_auto   <= 1'b0;
        end else begin
            prev_auto   <= auto_en;
            lane_upd    <= '0;
            frame_valid <= frame_done;
            if (!auto_en && din_valid && !sync_clr) begin
                data_out[sel] <= din;
                lane_upd[sel] <= 1'b1;
            end else if (frame_done) begin
                data_out <= frame_data;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= frame_bad;
        end
    end
`else
    logic unused_frame_bad;
    assign unused_frame_bad = frame_bad;
    assign parity_err       = 1'b0;
`endif

endmodule

// File: tb/tb_demux_1to4_deser.sv
// Self-checking bench for demux_1to4_deser: directed scenarios plus random traffic vs a queue-based model.
// Honours DEMUX_PARITY_EN (5-bit frames with even parity).
module tb_demux_1to4_deser;

`ifdef DEMUX_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic [1:0] sel = '0;
    logic       auto_en = 1'b0;
    logic       sync_clr = 1'b0;
    logic [3:0] data_out;
    logic [3:0] lane_upd;
    logic       frame_valid;
    logic       parity_err;

    int total = 0;
    int bad = 0;

    // Reference model: expected outputs plus the bits collected so far in auto mode.
    logic [3:0] m_data = '0;
    logic [3:0] m_upd = '0;
    logic       m_fv = 1'b0;
    logic       m_pe = 1'b0;
    logic       m_prev = 1'b0;
    logic       q[$];

    demux_1to4_deser #(.LANES(4), .SEL_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sel         (sel),
        .auto_en     (auto_en),
        .sync_clr    (sync_clr),
        .data_out    (data_out),
        .lane_upd    (lane_upd),
        .frame_valid (frame_valid),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Frame bits in transmission order: lane 0 first, then the even-parity bit if enabled.
    function automatic logic [4:0] frame_word(input logic [3:0] f);
        return {^f, f};
    endfunction

    task automatic step(input logic r, input logic v, input logic d, input logic a,
                        input logic c, input logic [1:0] s);
        logic [3:0] f;
        rst = r; din_valid = v; din = d; auto_en = a; sync_clr = c; sel = s;
        @(posedge clk);
        m_upd = '0; m_fv = 1'b0; m_pe = 1'b0;
        if (r) begin
            m_data = '0; m_prev = 1'b0; q.delete();
        end else begin
            if (a != m_prev) q.delete();
            m_prev = a;
            if (c) begin
                q.delete();
            end else if (v) begin
                if (!a) begin
                    m_data[s] = d;
                    m_upd[s]  = 1'b1;
                end else begin
                    q.push_back(d);
                    if (q.size() == FL) begin
                        for (int i = 0; i < 4; i++) f[i] = q[i];
`ifdef DEMUX_PARITY_EN
                        if ((^f) != q[4]) m_pe = 1'b1;
                        else begin m_data = f; m_fv = 1'b1; end
`else
                        m_data = f; m_fv = 1'b1;
`endif
                        q.delete();
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
            total++;
            if ({data_out, lane_upd, frame_valid, parity_err} !== 10'b0) begin
                bad++;
                $display("FAIL reset: got data=%b upd=%b fv=%b pe=%b, want all zero",
                         data_out, lane_upd, frame_valid, parity_err);
            end
        end
    endtask

    task automatic test_manual();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        total++;
        if (data_out !== 4'b0100 || lane_upd !== 4'b0100) begin
            bad++;
            $display("FAIL manual_sel2: got data=%b upd=%b, want 0100 0100", data_out, lane_upd);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        total++;
        if (data_out !== 4'b0101 || lane_upd !== 4'b0001) begin
            bad++;
            $display("FAIL manual_sel0: got data=%b upd=%b, want 0101 0001", data_out, lane_upd);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        total++;
        if (data_out !== 4'b0101 || lane_upd !== 4'b0000) begin
            bad++;
            $display("FAIL manual_idle: got data=%b upd=%b, want 0101 0000", data_out, lane_upd);
        end
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom_range(0, 7) == 0), 2'($urandom));
            total++;
            if ({data_out, lane_upd, frame_valid, parity_err} !== {m_data, m_upd, m_fv, m_pe}) begin
                bad++;
                $display("FAIL manual_rand: got %b %b %b %b, want %b %b %b %b", data_out, lane_upd,
                         frame_valid, parity_err, m_data, m_upd, m_fv, m_pe);
            end
        end
    endtask

    task automatic test_auto_basic();
        logic [4:0] w;
        w = frame_word(4'b1010);
        for (int i = 0; i < FL; i++) begin
            step(1'b0, 1'b1, w[i], 1'b1, 1'b0, 2'($urandom));
            total++;
            if ({data_out, lane_upd, frame_valid, parity_err} !== {m_data, m_upd, m_fv, m_pe}) begin
                bad++;
                $display("FAIL auto_basic bit%0d: got %b %b %b %b, want %b %b %b %b", i, data_out,
                         lane_upd, frame_valid, parity_err, m_data, m_upd, m_fv, m_pe);
            end
        end
        total++;
        if (data_out !== 4'b1010 || frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL auto_frame: got data=%b fv=%b, want 1010 1", data_out, frame_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        total++;
        if (frame_valid !== 1'b0 || data_out !== 4'b1010) begin
            bad++;
            $display("FAIL auto_pulse_len: got fv=%b data=%b, want 0 1010", frame_valid, data_out);
        end
    endtask

    task automatic test_sync_clr();
        logic [4:0] w;
        int fvs;
        fvs = 0;
        w = frame_word(4'b1111);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        fvs += int'(frame_valid);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        fvs += int'(frame_valid);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        fvs += int'(frame_valid);
        total++;
        if (data_out !== 4'b1010) begin
            bad++;
            $display("FAIL sync_clr_hold: got data=%b, want 1010", data_out);
        end
        for (int i = 0; i < FL; i++) begin
            step(1'b0, 1'b1, w[i], 1'b1, 1'b0, 2'd0);
            fvs += int'(frame_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        fvs += int'(frame_valid);
        total++;
        if (data_out !== 4'b1111 || fvs != 1) begin
            bad++;
            $display("FAIL sync_clr_frame: got data=%b pulses=%0d, want 1111 1", data_out, fvs);
        end
    endtask

    task automatic test_stall();
        logic [4:0] w0, w1;
        logic [9:0] bits;
        logic [3:0] seen[$];
        w0 = frame_word(4'b0001);
        w1 = frame_word(4'b1000);
        bits = {w1, w0};
        for (int i = 0; i < 2 * FL; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                step(1'b0, ph == 0, (i < FL) ? bits[i] : bits[i - FL + 5], 1'b1, 1'b0, 2'($urandom));
                if (frame_valid) seen.push_back(data_out);
                total++;
                if ({data_out, lane_upd, frame_valid, parity_err} !== {m_data, m_upd, m_fv, m_pe}) begin
                    bad++;
                    $display("FAIL stall bit%0d: got %b %b %b %b, want %b %b %b %b", i, data_out,
                             lane_upd, frame_valid, parity_err, m_data, m_upd, m_fv, m_pe);
                end
            end
        end
        total++;
        if (seen.size() != 2 || seen[0] !== 4'b0001 || seen[1] !== 4'b1000) begin
            bad++;
            $display("FAIL stall_frames: got %0d pulses, want 2 frames 0001 then 1000", seen.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] w;
        int fvs;
        fvs = 0;
        w = frame_word(4'b0110);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        total++;
        if ({data_out, lane_upd, frame_valid, parity_err} !== 10'b0) begin
            bad++;
            $display("FAIL reset_mid: got data=%b upd=%b fv=%b pe=%b, want all zero",
                     data_out, lane_upd, frame_valid, parity_err);
        end
        for (int i = 0; i < FL; i++) begin
            step(1'b0, 1'b1, w[i], 1'b1, 1'b0, 2'd0);
            fvs += int'(frame_valid);
        end
        total++;
        if (data_out !== 4'b0110 || fvs != 1 || frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_frame: got data=%b pulses=%0d, want 0110 1", data_out, fvs);
        end
    endtask

`ifdef DEMUX_PARITY_EN
    task automatic test_parity();
        logic [4:0] w;
        w = 5'b00011;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, w[i], 1'b1, 1'b0, 2'd0);
        total++;
        if (data_out !== 4'b0011 || frame_valid !== 1'b1 || parity_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_good: got data=%b fv=%b pe=%b, want 0011 1 0", data_out, frame_valid, parity_err);
        end
        w = 5'b10011;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, w[i], 1'b1, 1'b0, 2'd0);
        total++;
        if (data_out !== 4'b0011 || frame_valid !== 1'b0 || parity_err !== 1'b1) begin
            bad++;
            $display("FAIL parity_bad: got data=%b fv=%b pe=%b, want 0011 0 1", data_out, frame_valid, parity_err);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [4:0] w;
        int fvs;
        fvs = 0;
        for (int k = 0; k < 3; k++) begin
            w = frame_word(4'($urandom));
            for (int i = 0; i < FL; i++) begin
                step(1'b0, 1'b1, w[i], 1'b1, 1'b0, 2'd0);
                fvs += int'(frame_valid);
                total++;
                if ({data_out, lane_upd, frame_valid, parity_err} !== {m_data, m_upd, m_fv, m_pe}) begin
                    bad++;
                    $display("FAIL b2b f%0d bit%0d: got %b %b %b %b, want %b %b %b %b", k, i, data_out,
                             lane_upd, frame_valid, parity_err, m_data, m_upd, m_fv, m_pe);
                end
            end
        end
        total++;
        if (fvs != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d pulses, want 3", fvs);
        end
    endtask

    task automatic test_random();
        logic a;
        a = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) a = ~a;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom), a,
                 $urandom_range(0, 24) == 0, 2'($urandom));
            total++;
            if ({data_out, lane_upd, frame_valid, parity_err} !== {m_data, m_upd, m_fv, m_pe}) begin
                bad++;
                $display("FAIL random cyc%0d: got %b %b %b %b, want %b %b %b %b", i, data_out,
                         lane_upd, frame_valid, parity_err, m_data, m_upd, m_fv, m_pe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_basic();
        test_sync_clr();
        test_stall();
        test_reset_mid();
`ifdef DEMUX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1to4_deser.md
DEMUX_1TO4_DESER -- requirements
Module: demux_1to4_deser

Interface
REQ-001 SHALL have parameter LANES, default 4, number of output lanes; only 4 is supported.
REQ-002 SHALL have parameter SEL_W, default 2, width of lane select; fixed at log2(LANES).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port din, input, 1, serial data bit.
REQ-006 SHALL have port din_valid, input, 1, qualifies din for the current cycle.
REQ-007 SHALL have port sel, input, SEL_W, target lane in manual mode; ignored in auto mode.
REQ-008 SHALL have port auto_en, input, 1, 1 = auto (deserialize) mode, 0 = manual (addressed) mode.
REQ-009 SHALL have port sync_clr, input, 1, discards any partial frame and realigns to lane 0.
REQ-010 SHALL have port data_out, output, LANES, registered lane outputs.
REQ-011 SHALL have port lane_upd, output, LANES, one-cycle one-hot pulse marking the lane written in manual mode.
REQ-012 SHALL have port frame_valid, output, 1, one-cycle pulse when a complete auto-mode frame is presented.
REQ-013 SHALL have port parity_err, output, 1, one-cycle pulse on a frame with a parity failure (exists only under the macro; tied 0 otherwise).

Function
REQ-014 SHALL, in manual mode with din_valid=1, set data_out[sel] <= din one cycle later, hold all other bits, and pulse lane_upd[sel].
REQ-015 SHALL, in manual mode with din_valid=0, hold data_out and drive lane_upd=0.
REQ-016 SHALL, in auto mode, run FSM states S_L0, S_L1, S_L2, S_L3 (plus S_PAR under the macro); each din_valid stores din into shadow[state index] and advances to the next state; din_valid=0 stalls the FSM.
REQ-017 SHALL, on the valid bit in S_L3 (without the macro), copy the full shadow including that bit to data_out atomically, pulse frame_valid on the next cycle, and return to S_L0; frame latency is 1 cycle after the 4th bit.
REQ-018 SHALL keep data_out unchanged during auto-mode collection; partial frames are never visible.
REQ-019 SHALL, in auto mode, keep lane_upd=0 throughout.
REQ-020 SHALL, on any change of auto_en, return the FSM to S_L0 and discard the shadow; an input bit on that cycle is processed in the new mode from S_L0.
REQ-021 SHALL give sync_clr priority over din_valid: the FSM goes to S_L0, the shadow is cleared, the bit is dropped, and data_out holds.
REQ-022 SHALL allow back-to-back frames with din_valid held at 1, with no dead cycle between them.

Reset
REQ-023 SHALL, while rst=1, set data_out=4'b0000, lane_upd=0, frame_valid=0, parity_err=0, shadow=0, and FSM=S_L0.
REQ-024 SHALL let rst override sync_clr, din_valid and mode; a frame in progress is lost and no pulse is emitted.

Configuration
REQ-025 SHALL, with DEMUX_PARITY_EN defined, have auto mode expect a 5th bit (S_PAR) carrying even parity over the 4 data bits.
REQ-026 SHALL, on good parity, update data_out and pulse frame_valid; on bad parity, keep data_out, pulse parity_err, and not pulse frame_valid; both cases return to S_L0.
REQ-027 SHALL, without DEMUX_PARITY_EN, omit S_PAR, use 4-bit frames, and tie parity_err to 0.
REQ-028 SHALL leave manual mode unaffected by the macro.

Structure
REQ-029 SHALL place LANES, SEL_W and the FSM state enum in the shared package demux_pkg.
REQ-030 SHALL implement the auto-mode FSM and shadow register in the sub-module demux_frame_fsm; manual-mode writes, mode-change detection and output registers remain in the top level.

Verification
REQ-031 SHALL cover: manual mode, data_out=0, write din=1 to sel=2, then sel=0 -> data_out=4'b0101, lane_upd pulses 4'b0100 then 4'b0001.
REQ-032 SHALL cover: auto mode, bits 0,1,0,1 (lane0 first) -> data_out=4'b1010 one cycle after the 4th bit, frame_valid high exactly 1 cycle.
REQ-033 SHALL cover: auto mode, 2 bits sent, sync_clr asserted together with a 3rd bit, then 1,1,1,1 -> data_out=4'b1111, only one frame_valid.
REQ-034 SHALL cover: auto mode, din_valid toggling 1/0 across 8 bits 1,0,0,0,0,0,0,1 -> frames 4'b0001 then 4'b1000, two frame_valid pulses.
REQ-035 SHALL cover: rst asserted after 3 auto bits -> all outputs 0 next cycle, the following 4 bits form a fresh frame.
REQ-036 SHALL cover, under DEMUX_PARITY_EN: frame 1,1,0,0 with parity 0 -> frame_valid, data_out=4'b0011; with parity 1 -> parity_err, data_out unchanged.
